// File: rtl/spi_led_responder_if.sv
// SPI bus between the SAMD51 (master) and the iCE40 LED responder (slave).
// Mode 0, with SCK idling low.
interface spi_led_responder_if;
  logic spi_cs_n;
  logic spi_sck;
  logic spi_mosi;
  logic spi_miso;
  logic spi_miso_oe;

  modport master (output spi_cs_n, output spi_sck, output spi_mosi,
                  input spi_miso, input spi_miso_oe);
  modport slave  (input spi_cs_n, input spi_sck, input spi_mosi,
                  output spi_miso, output spi_miso_oe);
endinterface

// File: rtl/spi_led_responder.sv
// SPI mode-0 responder, oversampled by the system clock.
// It receives a 16-bit LED frame and returns the synchronized button state.
// Handshake: none on the SPI side; frame_stb and cmd_err are single-clk pulses.
module spi_led_responder #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] ID_BYTE     = 8'hA5
) (
  input  logic                clk,
  input  logic                resetn,
  spi_led_responder_if.slave  spi,
  input  logic [1:0]          btn,
  output logic [15:0]         led_frame,
  output logic                frame_stb,
  output logic                cmd_err,
  output logic [2:0]          dbg_state
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CMD    = 3'd1,
    WR_HI  = 3'd2,
    WR_LO  = 3'd3,
    RD     = 3'd4,
    DONE   = 3'd5,
    IGNORE = 3'd6
  } state_t;

  state_t                     state_q, state_d;
  logic [SYNC_STAGES-1:0]     cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0]     sck_sync_q, sck_sync_d;
  logic [SYNC_STAGES-1:0]     mosi_sync_q, mosi_sync_d;
  logic [2*SYNC_STAGES-1:0]   btn_sync_q, btn_sync_d;
  logic                       sck_prev_q, sck_prev_d;
  logic                       cs_prev_q, cs_prev_d;
  logic [2:0]                 bit_cnt_q, bit_cnt_d;
  logic [7:0]                 rx_sh_q, rx_sh_d;
  logic [7:0]                 tx_sh_q, tx_sh_d;
  logic [7:0]                 hi_q, hi_d;
  logic [15:0]                led_frame_q, led_frame_d;
  logic                       frame_stb_q, frame_stb_d;
  logic                       cmd_err_q, cmd_err_d;

  logic       cs_s, sck_s, mosi_s;
  logic [1:0] btn_s;
  logic       sck_rise, sck_fall, cs_rise, cs_fall;
  logic [7:0] rx_byte;

  always_comb begin
    cs_s     = cs_sync_q[SYNC_STAGES-1];
    sck_s    = sck_sync_q[SYNC_STAGES-1];
    mosi_s   = mosi_sync_q[SYNC_STAGES-1];
    btn_s    = btn_sync_q[2*SYNC_STAGES-1 -: 2];
    sck_rise = sck_s & ~sck_prev_q;
    sck_fall = ~sck_s & sck_prev_q;
    cs_rise  = cs_s & ~cs_prev_q;
    cs_fall  = ~cs_s & cs_prev_q;
    rx_byte  = {rx_sh_q[6:0], mosi_s};
  end

  always_comb begin
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], spi.spi_cs_n};
    sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], spi.spi_sck};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi.spi_mosi};
    btn_sync_d  = {btn_sync_q[2*SYNC_STAGES-3:0], btn};
    sck_prev_d  = sck_s;
    cs_prev_d   = cs_s;
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rx_sh_d     = rx_sh_q;
    tx_sh_d     = tx_sh_q;
    hi_d        = hi_q;
    led_frame_d = led_frame_q;
    frame_stb_d = 1'b0;
    cmd_err_d   = 1'b0;

    // Deselect has priority over any SCK edge seen in the same clk.
    if (cs_rise) begin
      state_d   = IDLE;
      bit_cnt_d = 3'd0;
      rx_sh_d   = 8'h00;
      tx_sh_d   = 8'h00;
      hi_d      = 8'h00;
    end else if (cs_fall) begin
      state_d   = CMD;
      bit_cnt_d = 3'd0;
      rx_sh_d   = 8'h00;
      tx_sh_d   = ID_BYTE;
    end else if (!cs_s && state_q != IDLE) begin
      if (sck_rise) begin
        rx_sh_d   = rx_byte;
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          case (state_q)
            CMD: begin
              if (rx_byte == 8'h01) begin
                state_d = WR_HI;
              end else if (rx_byte == 8'h02) begin
                state_d = RD;
              end else begin
                state_d   = IGNORE;
                cmd_err_d = 1'b1;
              end
            end
            WR_HI: begin
              hi_d    = rx_byte;
              state_d = WR_LO;
            end
            WR_LO: begin
              led_frame_d = {hi_q, rx_byte};
              frame_stb_d = 1'b1;
              state_d     = DONE;
            end
            default: state_d = state_q;
          endcase
        end
      end else if (sck_fall) begin
        // A fall with bit_cnt at 0 closes a byte: load the next outgoing byte.
        if (bit_cnt_q == 3'd0) begin
          tx_sh_d = (state_q == RD) ? {6'b0, btn_s} : 8'h00;
        end else begin
          tx_sh_d = {tx_sh_q[6:0], 1'b0};
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      cs_sync_q   <= '1;
      sck_sync_q  <= '0;
      mosi_sync_q <= '0;
      btn_sync_q  <= '0;
      sck_prev_q  <= 1'b0;
      cs_prev_q   <= 1'b1;
      bit_cnt_q   <= 3'd0;
      rx_sh_q     <= 8'h00;
      tx_sh_q     <= 8'h00;
      hi_q        <= 8'h00;
      led_frame_q <= 16'h0000;
      frame_stb_q <= 1'b0;
      cmd_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cs_sync_q   <= cs_sync_d;
      sck_sync_q  <= sck_sync_d;
      mosi_sync_q <= mosi_sync_d;
      btn_sync_q  <= btn_sync_d;
      sck_prev_q  <= sck_prev_d;
      cs_prev_q   <= cs_prev_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_sh_q     <= rx_sh_d;
      tx_sh_q     <= tx_sh_d;
      hi_q        <= hi_d;
      led_frame_q <= led_frame_d;
      frame_stb_q <= frame_stb_d;
      cmd_err_q   <= cmd_err_d;
    end
  end

  assign spi.spi_miso_oe = ~cs_s;
  assign spi.spi_miso    = ~cs_s & tx_sh_q[7];
  assign led_frame       = led_frame_q;
  assign frame_stb       = frame_stb_q;
  assign cmd_err         = cmd_err_q;
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_spi_led_responder.sv
// Directed bench for spi_led_responder: a master driving SCK at clk/8,
// with hand-computed MISO bytes, LED frames and pulse counts.
module tb_spi_led_responder;

  logic        clk;
  logic        resetn;
  logic [1:0]  btn;
  logic [15:0] led_frame;
  logic        frame_stb;
  logic        cmd_err;
  logic [2:0]  dbg_state;

  spi_led_responder_if bus();

  spi_led_responder #(.SYNC_STAGES(2), .ID_BYTE(8'hA5)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .spi       (bus),
    .btn       (btn),
    .led_frame (led_frame),
    .frame_stb (frame_stb),
    .cmd_err   (cmd_err),
    .dbg_state (dbg_state)
  );

  int tests;
  int fails;
  int stb_cnt;
  int err_cnt;
  int wide_cnt;
  logic prev_stb;
  logic prev_err;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired: got running want finished");
    $fatal(1, "watchdog");
  end

  // pulse monitors
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      prev_stb <= 1'b0;
      prev_err <= 1'b0;
    end else begin
      if (frame_stb) stb_cnt <= stb_cnt + 1;
      if (cmd_err) err_cnt <= err_cnt + 1;
      if ((frame_stb && prev_stb) || (cmd_err && prev_err)) wide_cnt <= wide_cnt + 1;
      prev_stb <= frame_stb;
      prev_err <= cmd_err;
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cs_low();
    bus.spi_cs_n = 1'b0;
    repeat (4) tick();
  endtask

  task automatic cs_high();
    repeat (4) tick();
    bus.spi_cs_n = 1'b1;
    repeat (6) tick();
  endtask

  task automatic spi_byte(input logic [7:0] tx, input int nbits, input bit chg_btn,
                          input logic [1:0] new_btn, input bit chk_stb,
                          output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      bus.spi_mosi = tx[7-i];
      repeat (4) tick();
      rx = {rx[6:0], bus.spi_miso};
      bus.spi_sck = 1'b1;
      if (chk_stb && i == 7) begin
        tick(); tick();
        tests++;
        if (frame_stb !== 1'b0) begin fails++; $display("FAIL stb_early got %b want 0", frame_stb); end
        tick();
        tests++;
        if (frame_stb !== 1'b1) begin fails++; $display("FAIL stb_on_time got %b want 1", frame_stb); end
        tick();
        tests++;
        if (frame_stb !== 1'b0) begin fails++; $display("FAIL stb_width got %b want 0", frame_stb); end
      end else begin
        repeat (4) tick();
      end
      bus.spi_sck = 1'b0;
      if (chg_btn && i == 3) btn = new_btn;
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) tick();
    tests++;
    if (led_frame !== 16'h0000 || frame_stb !== 1'b0 || cmd_err !== 1'b0 ||
        bus.spi_miso !== 1'b0 || bus.spi_miso_oe !== 1'b0 || dbg_state !== 3'd0) begin
      fails++;
      $display("FAIL reset_values got led=%h stb=%b err=%b miso=%b oe=%b st=%0d want 0000/0/0/0/0/0",
               led_frame, frame_stb, cmd_err, bus.spi_miso, bus.spi_miso_oe, dbg_state);
    end
    resetn = 1'b1;
    repeat (20) tick();
    tests++;
    if (led_frame !== 16'h0000 || bus.spi_miso_oe !== 1'b0 || dbg_state !== 3'd0 || stb_cnt !== 0) begin
      fails++;
      $display("FAIL idle_after_reset got led=%h oe=%b st=%0d stb=%0d want 0000/0/0/0",
               led_frame, bus.spi_miso_oe, dbg_state, stb_cnt);
    end
  endtask

  task automatic test_write();
    logic [7:0] r0, r1, r2;
    int s0;
    s0 = stb_cnt;
    cs_low();
    tests++;
    if (bus.spi_miso_oe !== 1'b1) begin fails++; $display("FAIL wr_oe got %b want 1", bus.spi_miso_oe); end
    spi_byte(8'h01, 8, 1'b0, 2'b00, 1'b0, r0);
    spi_byte(8'h5A, 8, 1'b0, 2'b00, 1'b0, r1);
    spi_byte(8'hC3, 8, 1'b0, 2'b00, 1'b1, r2);
    cs_high();
    tests++;
    if ({r0, r1, r2} !== 24'hA50000) begin
      fails++; $display("FAIL wr_miso got %h want a50000", {r0, r1, r2});
    end
    tests++;
    if (led_frame !== 16'h5AC3) begin fails++; $display("FAIL wr_led got %h want 5ac3", led_frame); end
    tests++;
    if (stb_cnt - s0 !== 1) begin fails++; $display("FAIL wr_stb_count got %0d want 1", stb_cnt - s0); end
    tests++;
    if (bus.spi_miso_oe !== 1'b0 || dbg_state !== 3'd0) begin
      fails++; $display("FAIL wr_deselect got oe=%b st=%0d want 0/0", bus.spi_miso_oe, dbg_state);
    end
  endtask

  task automatic test_read();
    logic [7:0] r0, r1, r2;
    int s0;
    s0 = stb_cnt;
    btn = 2'b10;
    repeat (4) tick();
    cs_low();
    spi_byte(8'h02, 8, 1'b0, 2'b00, 1'b0, r0);
    spi_byte(8'h00, 8, 1'b1, 2'b01, 1'b0, r1);
    spi_byte(8'h00, 8, 1'b0, 2'b00, 1'b0, r2);
    cs_high();
    tests++;
    if ({r0, r1, r2} !== 24'hA50201) begin
      fails++; $display("FAIL rd_miso got %h want a50201", {r0, r1, r2});
    end
    tests++;
    if (led_frame !== 16'h5AC3 || stb_cnt != s0) begin
      fails++; $display("FAIL rd_no_write got led=%h stb=%0d want 5ac3/0", led_frame, stb_cnt - s0);
    end
  endtask

  task automatic test_abort();
    logic [7:0] r;
    int s0;
    s0 = stb_cnt;
    cs_low();
    spi_byte(8'h01, 8, 1'b0, 2'b00, 1'b0, r);
    spi_byte(8'hFF, 8, 1'b0, 2'b00, 1'b0, r);
    spi_byte(8'hA0, 4, 1'b0, 2'b00, 1'b0, r);
    cs_high();
    tests++;
    if (led_frame !== 16'h5AC3 || stb_cnt != s0) begin
      fails++; $display("FAIL abort got led=%h stb=%0d want 5ac3/0", led_frame, stb_cnt - s0);
    end
    cs_low();
    spi_byte(8'h01, 8, 1'b0, 2'b00, 1'b0, r);
    spi_byte(8'h00, 8, 1'b0, 2'b00, 1'b0, r);
    spi_byte(8'h01, 8, 1'b0, 2'b00, 1'b0, r);
    cs_high();
    tests++;
    if (led_frame !== 16'h0001 || stb_cnt - s0 !== 1) begin
      fails++; $display("FAIL abort_recover got led=%h stb=%0d want 0001/1", led_frame, stb_cnt - s0);
    end
  endtask

  task automatic test_bad_cmd();
    logic [7:0] r0, r1, r2;
    int e0, s0;
    e0 = err_cnt;
    s0 = stb_cnt;
    cs_low();
    spi_byte(8'h7E, 8, 1'b0, 2'b00, 1'b0, r0);
    spi_byte(8'h11, 8, 1'b0, 2'b00, 1'b0, r1);
    spi_byte(8'h22, 8, 1'b0, 2'b00, 1'b0, r2);
    cs_high();
    tests++;
    if (err_cnt - e0 !== 1) begin fails++; $display("FAIL bad_err_count got %0d want 1", err_cnt - e0); end
    tests++;
    if ({r0, r1, r2} !== 24'hA50000) begin
      fails++; $display("FAIL bad_miso got %h want a50000", {r0, r1, r2});
    end
    tests++;
    if (led_frame !== 16'h0001 || stb_cnt != s0) begin
      fails++; $display("FAIL bad_led got led=%h stb=%0d want 0001/0", led_frame, stb_cnt - s0);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] r;
    logic [23:0] extra;
    int s0;
    s0 = stb_cnt;
    extra = 24'h0;
    cs_low();
    spi_byte(8'h01, 8, 1'b0, 2'b00, 1'b0, r);
    spi_byte(8'h12, 8, 1'b0, 2'b00, 1'b0, r);
    spi_byte(8'h34, 8, 1'b0, 2'b00, 1'b0, r);
    for (int k = 0; k < 3; k++) begin
      spi_byte(8'hFF, 8, 1'b0, 2'b00, 1'b0, r);
      extra = {extra[15:0], r};
    end
    cs_high();
    tests++;
    if (led_frame !== 16'h1234 || stb_cnt - s0 !== 1) begin
      fails++; $display("FAIL extra_bytes got led=%h stb=%0d want 1234/1", led_frame, stb_cnt - s0);
    end
    tests++;
    if (extra !== 24'h000000) begin fails++; $display("FAIL extra_miso got %h want 000000", extra); end
    s0 = stb_cnt;
    for (int k = 0; k < 16; k++) begin
      bus.spi_sck = ~bus.spi_sck;
      bus.spi_mosi = k[0];
      repeat (4) tick();
      tests++;
      if (bus.spi_miso_oe !== 1'b0) begin fails++; $display("FAIL idle_sck_oe got %b want 0", bus.spi_miso_oe); end
    end
    tests++;
    if (dbg_state !== 3'd0 || led_frame !== 16'h1234 || stb_cnt != s0 || bus.spi_miso !== 1'b0) begin
      fails++;
      $display("FAIL idle_sck got st=%0d led=%h stb=%0d miso=%b want 0/1234/0/0",
               dbg_state, led_frame, stb_cnt - s0, bus.spi_miso);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] r;
    cs_low();
    spi_byte(8'h01, 8, 1'b0, 2'b00, 1'b0, r);
    spi_byte(8'hBE, 4, 1'b0, 2'b00, 1'b0, r);
    #3;
    resetn = 1'b0;
    #1;
    tests++;
    if (led_frame !== 16'h0000 || bus.spi_miso_oe !== 1'b0 || bus.spi_miso !== 1'b0 ||
        frame_stb !== 1'b0 || dbg_state !== 3'd0) begin
      fails++;
      $display("FAIL mid_reset got led=%h oe=%b miso=%b stb=%b st=%0d want 0000/0/0/0/0",
               led_frame, bus.spi_miso_oe, bus.spi_miso, frame_stb, dbg_state);
    end
    bus.spi_cs_n = 1'b1;
    bus.spi_sck = 1'b0;
    repeat (3) tick();
    resetn = 1'b1;
    repeat (12) tick();
    tests++;
    if (led_frame !== 16'h0000 || bus.spi_miso_oe !== 1'b0 || dbg_state !== 3'd0) begin
      fails++;
      $display("FAIL post_reset_idle got led=%h oe=%b st=%0d want 0000/0/0",
               led_frame, bus.spi_miso_oe, dbg_state);
    end
    cs_low();
    spi_byte(8'h01, 8, 1'b0, 2'b00, 1'b0, r);
    spi_byte(8'hBE, 8, 1'b0, 2'b00, 1'b0, r);
    spi_byte(8'hEF, 8, 1'b0, 2'b00, 1'b0, r);
    cs_high();
    tests++;
    if (led_frame !== 16'hBEEF) begin fails++; $display("FAIL post_reset_write got %h want beef", led_frame); end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    stb_cnt = 0;
    err_cnt = 0;
    wide_cnt = 0;
    resetn = 1'b0;
    btn = 2'b00;
    bus.spi_cs_n = 1'b1;
    bus.spi_sck = 1'b0;
    bus.spi_mosi = 1'b0;
    test_reset();
    test_write();
    test_read();
    test_abort();
    test_bad_cmd();
    test_back_to_back();
    test_reset_mid();
    tests++;
    if (wide_cnt !== 0) begin fails++; $display("FAIL pulse_width got %0d wide pulses want 0", wide_cnt); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
